tile_painter: RTL and testbench
===============================

// Module: tile_painter
// PURPOSE
//  Parametrised tile drawer for the memory-sequence game; the successor of the tile lookup.
//  Resolves a tile ID from one of three sources: correct-answer, sequence step or boot
//  pattern. Maps the ID to a grid position and palette colour.
//  Streams every pixel of that tile to the VGA adapter as one (x, y, colour, plot) per clock,
//  with busy/done handshake to the game controller. Also supports an erase mode (colour 0).
// PARAMETERS
//  GRID_COLS   2   tiles per row; power of two
//  GRID_ROWS   2   tile rows; NUM_TILES = GRID_COLS*GRID_ROWS, IDW = clog2(NUM_TILES)
//  TILE_SIZE   8   tile edge in pixels; power of two
//  SEQ_LEN     9   steps held in seq; STW = clog2(SEQ_LEN)
//  XY_W        8   width of x and y outputs
//  COLOUR_W    3   colour width; requires NUM_TILES <= 2**COLOUR_W - 1
// PORTS
//  clock        in   1               system clock, rising edge
//  resetn       in   1               asynchronous, active-low reset
//  start        in   1               draw request, sampled only in IDLE
//  erase        in   1               with start: draw in colour 0 instead of palette colour
//  load_correct in   1               source select, highest priority
//  load_random  in   1               source select, second priority
//  correct      in   IDW             tile ID for the correct-answer source
//  boot         in   IDW             tile ID for the boot-pattern source (lowest priority)
//  step         in   STW             sequence index for the random source
//  seq          in   SEQ_LEN*IDW     packed sequence; step k uses seq[k*IDW +: IDW], seq[k*IDW] = ID MSB
//  x            out  XY_W            pixel x
//  y            out  XY_W            pixel y
//  colour       out  COLOUR_W        pixel colour
//  plot         out  1               pixel valid / VGA write enable
//  busy         out  1               high from accepted start until done
//  done         out  1               one-cycle pulse after the last pixel
//  err          out  1               one-cycle pulse: request rejected
// BEHAVIOUR
//  Reset (resetn=0, async): state IDLE; x=0, y=0, colour=0; plot, busy, done, err = 0;
//   pixel counters = 0. Reset mid-draw aborts immediately, with no done pulse.
//  FSM: IDLE -> LOAD -> DRAW -> DONE -> IDLE.
//   IDLE: on start=1, latch erase, sources, step and seq into registers.
//    Next state is LOAD; busy=1 from the next cycle.
//   LOAD (1 cycle): select ID with priority load_correct > load_random > boot.
//    Random source: reject if step >= SEQ_LEN; also reject if the ID is >= NUM_TILES.
//    On reject: err=1 for one cycle, go to IDLE with no plot and no done.
//    Otherwise register base_x = (ID % GRID_COLS)*TILE_SIZE,
//    base_y = (ID / GRID_COLS)*TILE_SIZE, and colour = erase ? 0 : ID+1.
//   DRAW: TILE_SIZE*TILE_SIZE cycles, plot=1 every cycle. x = base_x+px, y = base_y+py.
//    Raster order: px increments each cycle and wraps at TILE_SIZE-1, then py increments.
//    Last pixel is (base_x+TILE_SIZE-1, base_y+TILE_SIZE-1); counters clear on leaving DRAW.
//   DONE: plot=0, done=1 for one cycle, busy=0 in the same cycle; then IDLE.
//  Latency: start sampled at edge t; LOAD during t..t+1; first plot at edge t+2;
//   done asserted TILE_SIZE^2 cycles after the first plot.
//  x, y, colour are registered. Outside DRAW they hold their last value; plot is then 0.
//  Boundaries:
//   - start while busy is ignored and not queued.
//   - start held high re-triggers only from IDLE (back-to-back draws allowed).
//   - Source and seq inputs may change after acceptance without effect.
//   - Simultaneous load_correct and load_random: correct wins.
//   - err and done are never high in the same cycle.
// TESTING
//  1 Defaults, boot=3, start pulse -> 64 plots, x 8..15, y 8..15, colour 4, then one done pulse.
//  2 seq=18'b00_01_10_11_00_11_01_10_00 (MSB=step8), load_random=1, step=4 (ID 0) ->
//    x 0..7, y 0..7, colour 1.
//  3 load_correct=1 correct=1, load_random=1 step=0 -> correct wins: x 8..15, y 0..7, colour 2.
//  4 erase=1 boot=2 -> 64 plots at x 0..7, y 8..15, colour 0; start re-pulsed mid-draw ->
//    ignored, exactly 64 plots.
//  5 load_random=1 step=9 -> err pulse 1 cycle after acceptance, plot never 1, no done.
//  6 resetn=0 after 20 plots -> plot, busy, done = 0 at once; next start draws a full 64 pixels.
//    Also repeat case 1 with GRID_COLS=4, TILE_SIZE=16, ID 5 -> x 16..31, y 16..31, colour 6.

Source files
------------

// File: rtl/tile_painter.sv
// Tile painter for the memory-sequence game: resolves a tile ID from one of three sources,
// then streams every pixel of that tile to the VGA adapter with a busy/done/err handshake.
module tile_painter #(
  parameter int GRID_COLS  = 2,
  parameter int GRID_ROWS  = 2,
  parameter int TILE_SIZE  = 8,
  parameter int SEQ_LEN    = 9,
  parameter int XY_W       = 8,
  parameter int COLOUR_W   = 3,
  localparam int NUM_TILES = GRID_COLS * GRID_ROWS,
  localparam int IDW       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
  localparam int STW       = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   erase,
  input  logic                   load_correct,
  input  logic                   load_random,
  input  logic [IDW-1:0]         correct,
  input  logic [IDW-1:0]         boot,
  input  logic [STW-1:0]         step,
  input  logic [SEQ_LEN*IDW-1:0] seq,
  output logic [XY_W-1:0]        x,
  output logic [XY_W-1:0]        y,
  output logic [COLOUR_W-1:0]    colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int            PW     = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TILE_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;
  state_t state_q, state_d;

  // Request captured at acceptance; later input changes cannot disturb a draw.
  logic                   erase_q, lc_q, lr_q;
  logic [IDW-1:0]         correct_q, boot_q;
  logic [STW-1:0]         step_q;
  logic [SEQ_LEN*IDW-1:0] seq_q;

  logic [XY_W-1:0]        base_x_q, base_y_q;
  logic [COLOUR_W-1:0]    tile_colour_q;
  logic [PW-1:0]          px_q, py_q;

  logic [IDW-1:0]         rand_id, sel_id;
  logic                   sel_ok, accept, reject, last_pix;
  logic [XY_W-1:0]        tile_x, tile_y;
  logic [COLOUR_W-1:0]    tile_colour;

  // Sequence entries are stored MSB-first: seq[k*IDW] is the most significant ID bit.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    rand_id = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (32'(step_q) == 32'(k)) begin
        for (int i = 0; i < IDW; i++) rand_id[IDW-1-i] = seq_q[k*IDW + i];
      end
    end
  end

  always_comb begin
    sel_id = boot_q;
    sel_ok = 1'b1;
    if (lc_q) begin
      sel_id = correct_q;
    end else if (lr_q) begin
      sel_id = rand_id;
      if (32'(step_q) >= 32'(SEQ_LEN)) sel_ok = 1'b0;
    end
    if (32'(sel_id) >= 32'(NUM_TILES)) sel_ok = 1'b0;
    tile_x      = XY_W'((32'(sel_id) % 32'(GRID_COLS)) * 32'(TILE_SIZE));
    tile_y      = XY_W'((32'(sel_id) / 32'(GRID_COLS)) * 32'(TILE_SIZE));
    tile_colour = erase_q ? '0 : COLOUR_W'(32'(sel_id) + 32'd1);
  end

  assign last_pix = (px_q == P_LAST) && (py_q == P_LAST);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        accept  = 1'b1;
      end
      S_LOAD: if (sel_ok) begin
        state_d = S_DRAW;
      end else begin
        state_d = S_IDLE;
        reject  = 1'b1;
      end
      S_DRAW:  if (last_pix) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Handshake and pixel outputs are registered one cycle behind the state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      erase_q       <= 1'b0;
      lc_q          <= 1'b0;
      lr_q          <= 1'b0;
      correct_q     <= '0;
      boot_q        <= '0;
      step_q        <= '0;
      seq_q         <= '0;
      base_x_q      <= '0;
      base_y_q      <= '0;
      tile_colour_q <= '0;
      px_q          <= '0;
      py_q          <= '0;
      x             <= '0;
      y             <= '0;
      colour        <= '0;
      plot          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= (state_q == S_DONE);
      err  <= reject;
      plot <= (state_q == S_DRAW);

      if (accept) begin
        erase_q   <= erase;
        lc_q      <= load_correct;
        lr_q      <= load_random;
        correct_q <= correct;
        boot_q    <= boot;
        step_q    <= step;
        seq_q     <= seq;
      end

      if (state_q == S_LOAD && sel_ok) begin
        base_x_q      <= tile_x;
        base_y_q      <= tile_y;
        tile_colour_q <= tile_colour;
      end

      if (state_q == S_DRAW) begin
        x      <= base_x_q + XY_W'(px_q);
        y      <= base_y_q + XY_W'(py_q);
        colour <= tile_colour_q;
        if (px_q == P_LAST) begin
          px_q <= '0;
          py_q <= py_q + 1'b1;
        end else begin
          px_q <= px_q + 1'b1;
        end
      end else begin
        px_q <= '0;
        py_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_painter.sv
// Self-checking bench for tile_painter: table of draw requests plus hand-written sequences
// for mid-draw restart, held start, reset mid-draw and a larger-grid instance.
module tb_tile_painter;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start, erase, load_correct, load_random;
  logic [1:0]  correct, boot;
  logic [3:0]  step;
  logic [17:0] seq;
  logic [7:0]  x, y;
  logic [2:0]  colour;
  logic        plot, busy, done, err;

  logic        start2;
  logic [2:0]  boot2;
  logic [7:0]  x2, y2;
  logic [3:0]  colour2;
  logic        plot2, busy2, done2, err2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] c;
  } pix2_t;

  typedef struct {
    string       name;
    logic        lc;
    logic        lr;
    logic        erase;
    logic [1:0]  correct;
    logic [1:0]  boot;
    logic [3:0]  step;
    logic [17:0] seq;
    logic        exp_err;
    int          bx;
    int          by;
    int          col;
  } vec_t;

  pix_t  sb[$];
  pix2_t sb2[$];
  vec_t  vecs[10];

  localparam logic [17:0] SEQ_T2 = 18'b00_01_10_11_00_11_01_10_00;

  tile_painter dut (
    .clock(clock), .resetn(resetn), .start(start), .erase(erase),
    .load_correct(load_correct), .load_random(load_random),
    .correct(correct), .boot(boot), .step(step), .seq(seq),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done), .err(err)
  );

  tile_painter #(.GRID_COLS(4), .GRID_ROWS(2), .TILE_SIZE(16), .COLOUR_W(4)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2), .erase(1'b0),
    .load_correct(1'b0), .load_random(1'b0),
    .correct(3'd0), .boot(boot2), .step(4'd0), .seq(27'd0),
    .x(x2), .y(y2), .colour(colour2), .plot(plot2), .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_tile(input int bx, input int by, input int col);
    for (int py = 0; py < 8; py++)
      for (int px = 0; px < 8; px++)
        sb.push_back('{x: 8'(bx + px), y: 8'(by + py), c: 3'(col)});
  endtask

  task automatic take_pixel(input string name);
    pix_t e;
    if (sb.size() == 0) begin
      check({name, " unexpected plot"}, longint'(plot), 0);
    end else begin
      e = sb.pop_front();
      check({name, " pixel"}, longint'({x, y, colour}), longint'({e.x, e.y, e.c}));
    end
  endtask

  // Called on a falling edge with the DUT idle; pulse_at > 0 re-pulses start mid-draw.
  task automatic run_vec(input vec_t v, input int pulse_at);
    int first_plot, done_cyc, err_cyc, plots, errs;
    first_plot = -1; done_cyc = -1; err_cyc = -1; plots = 0; errs = 0;
    load_correct = v.lc; load_random = v.lr; erase = v.erase;
    correct = v.correct; boot = v.boot; step = v.step; seq = v.seq;
    start = 1'b1;
    if (!v.exp_err) push_tile(v.bx, v.by, v.col);
    @(negedge clock);
    start = 1'b0;
    load_correct = ~v.lc; load_random = ~v.lr; erase = ~v.erase;
    correct = ~v.correct; boot = ~v.boot; step = ~v.step; seq = ~v.seq;
    check({v.name, " busy after accept"}, longint'(busy), 1);
    for (int cyc = 2; cyc <= 150; cyc++) begin
      start = (cyc == pulse_at);
      @(negedge clock);
      check({v.name, " err with done"}, longint'(err & done), 0);
      if (plot) begin
        plots++;
        if (first_plot < 0) first_plot = cyc;
        take_pixel(v.name);
      end
      if (err) begin
        errs++;
        if (err_cyc < 0) err_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        check({v.name, " busy low with done"}, longint'(busy), 0);
        break;
      end
      if (v.exp_err && cyc >= 8) break;
    end
    start = 1'b0;
    if (v.exp_err) begin
      check({v.name, " err cycle"}, err_cyc, 2);
      check({v.name, " err pulses"}, errs, 1);
      check({v.name, " plots"}, plots, 0);
      check({v.name, " done cycle"}, done_cyc, -1);
      check({v.name, " busy after err"}, longint'(busy), 0);
    end else begin
      check({v.name, " first plot cycle"}, first_plot, 3);
      check({v.name, " done cycle"}, done_cyc, 67);
      check({v.name, " plots"}, plots, 64);
      check({v.name, " errs"}, errs, 0);
    end
    check({v.name, " leftover pixels"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int plots, dones, done_a, done_b, second_first;
    vecs[0] = '{"boot3",      1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 4'd0,  18'd0,  1'b0, 8, 8, 4};
    vecs[1] = '{"rand_step4", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd4,  SEQ_T2, 1'b0, 0, 0, 1};
    vecs[2] = '{"corr_wins",  1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 4'd0,  SEQ_T2, 1'b0, 8, 0, 2};
    vecs[3] = '{"erase_boot2",1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 4'd0,  18'd0,  1'b0, 0, 8, 0};
    vecs[4] = '{"rand_step9", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd9,  SEQ_T2, 1'b1, 0, 0, 0};
    vecs[5] = '{"rand_step6", 1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 4'd6,  SEQ_T2, 1'b0, 8, 0, 2};
    vecs[6] = '{"rand_step7", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd7,  SEQ_T2, 1'b0, 0, 8, 3};
    vecs[7] = '{"rand_step15",1'b0, 1'b1, 1'b0, 2'd3, 2'd3, 4'd15, SEQ_T2, 1'b1, 0, 0, 0};
    vecs[8] = '{"erase_corr0",1'b1, 1'b0, 1'b1, 2'd0, 2'd3, 4'd0,  18'd0,  1'b0, 0, 0, 0};
    vecs[9] = '{"boot0",      1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 4'd0,  18'd0,  1'b0, 0, 0, 1};

    resetn = 1'b0; start = 1'b0; erase = 1'b0; load_correct = 1'b0; load_random = 1'b0;
    correct = '0; boot = '0; step = '0; seq = '0; start2 = 1'b0; boot2 = '0;
    repeat (3) @(negedge clock);
    check("reset outputs", longint'({x, y, colour, plot, busy, done, err}), 0);
    resetn = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], (i == 3) ? 20 : -1);

    // Start held high: two back-to-back draws with a two-cycle gap, then release.
    load_correct = 1'b0; load_random = 1'b0; erase = 1'b0; boot = 2'd1;
    push_tile(8, 0, 2);
    push_tile(8, 0, 2);
    plots = 0; dones = 0; done_a = -1; done_b = -1; second_first = -1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 140; cyc++) begin
      if (cyc == 130) start = 1'b0;
      @(negedge clock);
      if (plot) begin
        plots++;
        if (done_a > 0 && second_first < 0) second_first = cyc;
        take_pixel("held");
      end
      if (done) begin
        dones++;
        if (done_a < 0) done_a = cyc;
        else done_b = cyc;
      end
    end
    start = 1'b0;
    check("held plots", plots, 128);
    check("held dones", dones, 2);
    check("held done 1", done_a, 67);
    check("held second first plot", second_first, 70);
    check("held done 2", done_b, 134);
    check("held leftover", sb.size(), 0);
    sb.delete();

    // Reset after 20 plots aborts the draw at once.
    boot = 2'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    plots = 0;
    for (int cyc = 2; cyc <= 100 && plots < 20; cyc++) begin
      @(negedge clock);
      if (plot) plots++;
    end
    check("reset abort plots seen", plots, 20);
    resetn = 1'b0;
    #1;
    check("reset abort plot", longint'(plot), 0);
    check("reset abort busy", longint'(busy), 0);
    check("reset abort done", longint'(done), 0);
    check("reset abort xyc", longint'({x, y, colour}), 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("no done after abort", longint'(done), 0);
    run_vec(vecs[0], -1);

    // Larger grid: 4 columns, 16-pixel tiles, tile 5.
    for (int py = 0; py < 16; py++)
      for (int px = 0; px < 16; px++)
        sb2.push_back('{x: 8'(16 + px), y: 8'(16 + py), c: 4'd6});
    boot2 = 3'd5;
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    plots = 0; done_a = -1; second_first = -1;
    for (int cyc = 2; cyc <= 400; cyc++) begin
      @(negedge clock);
      if (plot2) begin
        pix2_t e;
        plots++;
        if (second_first < 0) second_first = cyc;
        if (sb2.size() == 0) begin
          check("big unexpected plot", longint'(plot2), 0);
        end else begin
          e = sb2.pop_front();
          check("big pixel", longint'({x2, y2, colour2}), longint'({e.x, e.y, e.c}));
        end
      end
      if (done2) begin
        done_a = cyc;
        check("big busy with done", longint'(busy2), 0);
        break;
      end
    end
    check("big first plot", second_first, 3);
    check("big done cycle", done_a, 259);
    check("big plots", plots, 256);
    check("big err", longint'(err2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
